// File: rtl/fifo_packer_pkg.sv
// fifo_packer_pkg: shared state type and counter-width helper for the FIFO read packer
package fifo_packer_pkg;
  typedef enum logic [1:0] {FILL, FLUSH, OUT} packer_state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fifo_read_packer.sv
// fifo_read_packer: pops FIFO words and packs PACK_WORDS of them into one valid/ready beat
module fifo_read_packer
  import fifo_packer_pkg::*;
#(
  parameter int DATA_BITS = 10,
  parameter int PACK_WORDS = 4,
  localparam int CNT_W = cnt_width(PACK_WORDS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            fifo_empty,
  output logic                            fifo_read,
  input  logic [DATA_BITS-1:0]            fifo_data,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_BITS*PACK_WORDS-1:0] out_data,
  output logic [CNT_W-1:0]                out_count,
  output logic                            busy
);
  localparam logic [CNT_W:0] PACK_N = (CNT_W + 1)'(PACK_WORDS);
  packer_state_t state, state_nx;
  logic [CNT_W-1:0] fill_cnt;
  logic inflight, flush_pend;
  logic [DATA_BITS-1:0] lane [PACK_WORDS];
  logic [CNT_W:0] pending;
  logic full, take_flush, hs;
  assign pending = {1'b0, fill_cnt} + {{CNT_W{1'b0}}, inflight};
  assign full = inflight && pending == PACK_N;
  assign take_flush = state == FILL && flush && pending != '0;
  assign hs = state == OUT && out_ready;
  assign fifo_read = reset && state == FILL && !fifo_empty && pending < PACK_N && !flush_pend && !flush;
  assign out_valid = state == OUT;
  assign out_count = state == OUT ? fill_cnt : '0;
  assign busy = fill_cnt != '0 || inflight || state != FILL;
  // Next state: a word landing that completes the beat beats a flush; FLUSH only lasts until the in-flight word lands
  always_comb begin
    state_nx = state;
    state_nx = state == FILL ? (full ? OUT : take_flush ? FLUSH : FILL)
             : state == FLUSH ? OUT
             : (hs ? FILL : OUT);
  end
  // State, counters and the pending-read / pending-flush flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FILL;
      fill_cnt <= '0;
      inflight <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= fifo_read;
      flush_pend <= state_nx == OUT ? 1'b0 : take_flush ? 1'b1 : flush_pend;
      fill_cnt <= hs ? '0 : inflight ? fill_cnt + 1'b1 : fill_cnt;
    end
  end
  for (genvar i = 0; i < PACK_WORDS; i++) begin : g_lane
    // Each lane captures the landing word when it is the next slot; cleared when the beat is accepted
    always_ff @(posedge clk) begin
      if (!reset || hs) lane[i] <= '0;
      else if (inflight && fill_cnt == CNT_W'(i)) lane[i] <= fifo_data;
    end
    assign out_data[i*DATA_BITS +: DATA_BITS] = lane[i];
  end
endmodule

// File: tb/tb_fifo_read_packer.sv
// tb_fifo_read_packer: randomized and directed checks of the packer against a word-queue model
module tb_fifo_read_packer;
  localparam int DB = 10;
  localparam int PW = 4;
  localparam int CW = 3;
  localparam int OW = DB * PW;
  logic clk = 0, reset = 0, flush = 0, out_ready = 0;
  logic fifo_empty, fifo_read, out_valid, busy;
  logic [DB-1:0] fifo_data = '0;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_count;
  int checks = 0, errors = 0;
  logic [DB-1:0] mem [0:1023];
  int wp = 0, rp = 0;

  fifo_read_packer #(.DATA_BITS(DB), .PACK_WORDS(PW)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .fifo_data(fifo_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO read side with one-cycle read latency
  assign fifo_empty = (rp == wp);
  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_data <= mem[rp];
      rp <= rp + 1;
    end
  end

  task automatic push(input logic [DB-1:0] w);
    mem[wp] = w;
    wp++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] pack_words(input logic [DB-1:0] w [$], input int n);
    logic [OW-1:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (OW'(w[k]) << (k * DB));
    return v;
  endfunction

  task automatic wait_valid(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy && !out_valid) break;
    end
    tick();
  endtask

  task automatic test_reset();
    logic [DB-1:0] w [$];
    bit ok;
    w = '{10'h00A, 10'h00B, 10'h00C, 10'h00D};
    foreach (w[k]) push(w[k]);
    reset = 0;
    out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({fifo_read, out_valid, out_data, out_count, busy} !== '0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: rd=%b vld=%b data=%h cnt=%0d busy=%b, required all 0", c, fifo_read, out_valid, out_data, out_count, busy);
      end
    end
    tick();
    reset = 1;
    wait_valid(20, ok);
    checks++;
    if (!ok || out_data !== pack_words(w, 4) || out_count !== 3'd4) begin
      errors++;
      $display("FAIL reset_first_beat: got valid=%b data=%h cnt=%0d, required data=%h cnt=4", ok, out_data, out_count, pack_words(w, 4));
    end
    tick();
  endtask

  task automatic test_single();
    int nr = 0, nv = 0, first = -1, last = -1, vc = -1;
    logic [OW-1:0] vd = '0;
    logic [CW-1:0] vcnt = '0;
    wait_idle();
    out_ready = 1;
    for (int k = 1; k <= 4; k++) push(DB'(k));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (fifo_read) begin
        if (nr == 0) first = c;
        last = c;
        nr++;
      end
      if (out_valid) begin
        nv++;
        vc = c;
        vd = out_data;
        vcnt = out_count;
      end
    end
    checks++;
    if (nr != 4) begin errors++; $display("FAIL single_reads: got %0d reads, required 4", nr); end
    checks++;
    if (last - first != 3) begin errors++; $display("FAIL single_consecutive: span %0d, required 3", last - first); end
    checks++;
    if (nv != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d, required 1", nv); end
    checks++;
    if (vc != last + 2) begin errors++; $display("FAIL single_latency: valid at %0d, required %0d", vc, last + 2); end
    checks++;
    if (vd !== 40'h01_0030_0801) begin errors++; $display("FAIL single_data: got %h, required 0100300801", vd); end
    checks++;
    if (vcnt !== 3'd4) begin errors++; $display("FAIL single_count: got %0d, required 4", vcnt); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DB-1:0] w [$];
    logic [OW-1:0] b1, b2;
    bit ok;
    bit found = 0;
    wait_idle();
    out_ready = 0;
    for (int k = 0; k < 8; k++) w.push_back(DB'($urandom));
    foreach (w[k]) push(w[k]);
    b1 = pack_words(w, 4);
    w = w[4:7];
    b2 = pack_words(w, 4);
    wait_valid(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_first_valid: no beat within 20 cycles"); end
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== b1 || fifo_read !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall cycle %0d: vld=%b data=%h rd=%b, required vld=1 data=%h rd=0", c, out_valid, out_data, fifo_read, b1);
      end
    end
    tick();
    out_ready = 1;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found || out_data !== b2 || out_count !== 3'd4) begin
      errors++;
      $display("FAIL bp_second_beat: found=%b data=%h cnt=%0d, required data=%h cnt=4 within 6 cycles", found, out_data, out_count, b2);
    end
    tick();
  endtask

  task automatic test_flush_partial();
    bit ok;
    wait_idle();
    out_ready = 1;
    push(10'h3FF);
    push(10'h155);
    repeat (5) tick();
    flush = 1;
    tick();
    flush = 0;
    wait_valid(6, ok);
    checks++;
    if (!ok || out_data !== 40'h00_0005_57FF || out_count !== 3'd2) begin
      errors++;
      $display("FAIL flush_partial: valid=%b data=%h cnt=%0d, required data=00000557ff cnt=2", ok, out_data, out_count);
    end
    tick();
  endtask

  task automatic test_flush_race();
    logic [DB-1:0] w [$];
    logic [DB-1:0] rest [$];
    int n = 0;
    bit ok;
    wait_idle();
    out_ready = 1;
    for (int k = 0; k < 6; k++) w.push_back(DB'($urandom));
    rest = w[3:5];
    foreach (w[k]) push(w[k]);
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (fifo_read) n++;
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL race_third_read: saw %0d reads, required 3", n); end
    tick();
    flush = 1;
    @(negedge clk);
    checks++;
    if (fifo_read !== 1'b0 || fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL race_suppress: rd=%b empty=%b, required rd=0 empty=0", fifo_read, fifo_empty);
    end
    tick();
    flush = 0;
    wait_valid(6, ok);
    checks++;
    if (!ok || out_count !== 3'd3 || out_data !== pack_words(w, 3)) begin
      errors++;
      $display("FAIL race_beat: valid=%b data=%h cnt=%0d, required data=%h cnt=3", ok, out_data, out_count, pack_words(w, 3));
    end
    tick();
    repeat (6) tick();
    flush = 1;
    tick();
    flush = 0;
    wait_valid(6, ok);
    checks++;
    if (!ok || out_count !== 3'd3 || out_data !== pack_words(rest, 3)) begin
      errors++;
      $display("FAIL race_rest: valid=%b data=%h cnt=%0d, required data=%h cnt=3", ok, out_data, out_count, pack_words(rest, 3));
    end
    tick();
  endtask

  task automatic test_flush_empty_and_reset_out();
    bit ok;
    int nv = 0;
    wait_idle();
    flush = 1;
    tick();
    flush = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL flush_empty: %0d valid cycles, required 0", nv); end
    tick();
    out_ready = 0;
    for (int k = 0; k < 4; k++) push(DB'($urandom));
    wait_valid(12, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_out_setup: no beat within 12 cycles"); end
    tick();
    reset = 0;
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_count !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_out_drop: vld=%b cnt=%0d data=%h, required all 0", out_valid, out_count, out_data);
    end
    tick();
    reset = 1;
    out_ready = 1;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL reset_out_nobeat: %0d valid cycles, required 0", nv); end
    tick();
  endtask

  task automatic test_random();
    logic [DB-1:0] exp_q [$];
    logic [DB-1:0] w4 [$];
    int pushed = 0, beats = 0;
    bit done = 0;
    wait_idle();
    for (int c = 0; c < 3000; c++) begin
      if (pushed < 40 && $urandom_range(0, 2) == 0) begin
        int n = $urandom_range(1, 3);
        for (int k = 0; k < n && pushed < 40; k++) begin
          logic [DB-1:0] v = DB'($urandom);
          push(v);
          exp_q.push_back(v);
          pushed++;
        end
      end
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        w4 = exp_q[0:3];
        checks++;
        if (out_data !== pack_words(w4, 4) || out_count !== 3'd4) begin
          errors++;
          $display("FAIL random_beat %0d: data=%h cnt=%0d, required data=%h cnt=4", beats, out_data, out_count, pack_words(w4, 4));
        end
        repeat (4) void'(exp_q.pop_front());
        beats++;
      end
      tick();
      if (pushed == 40 && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done || beats != 10) begin
      errors++;
      $display("FAIL random_complete: beats=%0d left=%0d, required 10 beats and 0 left", beats, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_flush_partial();
    test_flush_race();
    test_flush_empty_and_reset_out();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_read_packer.md
Name: fifo_read_packer

Overview:
- Downstream consumer on the read side of the asynchronous FIFO, in the FIFO read clock domain.
- Pops DATA_BITS-wide words whenever the FIFO is non-empty and packs PACK_WORDS consecutive words into one wide output beat.
- Presents each beat on a valid/ready stream to the next stage.
- A flush input forces out a partially filled beat with its word count.

Parameters:
- DATA_BITS, 10, width of one FIFO word; must match the FIFO's data width.
- PACK_WORDS, 4, FIFO words per output beat; legal range 2..16.
- CNT_W, $clog2(PACK_WORDS+1), derived localparam; width of the word counters. Not overridable.

Ports:
- clk  input  1  read-domain clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- fifo_empty  input  1  FIFO empty flag.
- fifo_read  output  1  FIFO pop request.
- fifo_data  input  DATA_BITS  FIFO output data.
- flush  input  1  request to emit a partial beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_BITS*PACK_WORDS  packed beat.
- out_count  output  CNT_W  number of valid words in out_data.
- busy  output  1  high when fill_cnt != 0, a read is in flight, or state != FILL.

Behaviour:
- Reset (reset==0 at clk edge):
  - fifo_read=0, out_valid=0, out_data=0, out_count=0, busy=0, state=FILL, fill_cnt=0, inflight=0.
  - A word popped in the cycle before reset is discarded.
- FIFO read latency is 1 cycle: fifo_data is valid the cycle after fifo_read=1 with fifo_empty=0. inflight tracks this.
- fifo_read is combinational: state==FILL && !fifo_empty && (fill_cnt + inflight) < PACK_WORDS && !flush_pend. It never asserts while fifo_empty=1.
- Packing:
  - The k-th captured word goes to out_data[k*DATA_BITS +: DATA_BITS].
  - Word 0 is the first word popped and occupies the LSBs.
  - Unused lanes are 0.
- States:
  - FILL: capture fifo_data when inflight=1 and increment fill_cnt. When a capture makes fill_cnt==PACK_WORDS, go to OUT.
  - FLUSH: no new reads. Wait for inflight to clear, capturing the landing word. Then go to OUT with out_count=fill_cnt.
  - OUT: out_valid=1. out_data and out_count are held stable until out_valid && out_ready. On that handshake: clear the accumulator, fill_cnt=0, return to FILL, out_valid=0 in the next cycle.
- Flush rules:
  - flush is sampled only in FILL.
  - If fill_cnt + inflight > 0, set flush_pend and go to FLUSH.
  - If fill_cnt + inflight == 0, flush is ignored; no empty beat is ever emitted.
  - flush asserted in FLUSH or OUT is ignored.
  - flush_pend clears on entry to OUT.
- Simultaneous events:
  - flush arriving in the same cycle as a fifo_read pop: fifo_read is suppressed combinationally by flush in FILL, so no new pop occurs. Any word already in flight is still included in the beat.
  - fifo_empty rising while a read is in flight has no effect on capture.
- Throughput: with a never-empty FIFO and out_ready held at 1, one beat every PACK_WORDS+2 cycles.
- Backpressure: while in OUT, fifo_read=0; the FIFO absorbs the stall.
- Reset mid-operation: takes effect at the next edge from any state. A beat held in OUT is dropped (out_valid=0 next cycle).
- Counter widths: fill_cnt + inflight is evaluated at CNT_W+1 bits; no wrap is possible.

Decomposition:
- Package fifo_packer_pkg holds:
  - typedef enum logic [1:0] {FILL, FLUSH, OUT} packer_state_t;
  - function cnt_width(int n) returning $clog2(n+1).
- Single module; no sub-module. The accumulator is a simple array of PACK_WORDS registers with per-lane write enables.
- The bench connects the FIFO read side through the existing FIFO interface, using its RTL-side signals.

Test Plan (DATA_BITS=10, PACK_WORDS=4):
- Hold reset=0 for 3 cycles with fifo_empty=0 -> fifo_read=0, out_valid=0, out_data=0, out_count=0, busy=0 throughout.
- FIFO holds 0x001,0x002,0x003,0x004 and out_ready=1 -> fifo_read high for 4 consecutive cycles; out_valid high for exactly 1 cycle, 2 cycles after the last read; out_data=40'h01_0030_0801, out_count=4.
- FIFO holds 8 words and out_ready=0 for 10 cycles -> first beat's out_valid held and out_data stable for the whole stall, fifo_read=0 during OUT; after out_ready=1 the second beat follows within 6 cycles.
- Push 0x3FF,0x155, leave the FIFO empty, then pulse flush -> out_data=40'h00_0005_57FF, out_count=2, upper lanes 0.
- Pulse flush in the same cycle as the pop of the 3rd word -> no 4th pop even with the FIFO non-empty; out_count=3 and the 3rd word is in lane 2.
- Pulse flush with an empty accumulator and no read in flight -> no out_valid. Then assert reset=0 while in OUT -> out_valid=0 on the next cycle and no beat is delivered.
